cdc_handshake_transmitter: RTL and testbench

Source-domain end of a four-phase req/ack clock-domain crossing for a multi-bit word. It accepts a word over a valid/ready interface, holds it stable on data_out, and raises req_out. It then waits for the destination's ack to come back through an internal flop synchronizer before releasing the bus. It pairs with a destination-side receiver that synchronizes req_out, samples data_out and drives ack_in.

---
 rtl/cdc_handshake_transmitter_pkg.sv | 17 +
 rtl/cdc_handshake_transmitter_sync.sv | 55 +++++
 rtl/cdc_handshake_transmitter.sv | 119 +++++++++++
 tb/tb_cdc_handshake_transmitter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_handshake_transmitter_pkg.sv
// Shared definitions for the source side of the four-phase req/ack crossing:
// FSM state encoding and the holdoff counter sizing rule.
package cdc_handshake_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_HOLDOFF = 2'd0,
        ST_IDLE    = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Counter must reach SYNC_STAGES+1, so it needs clog2(SYNC_STAGES+2) bits.
    function automatic int unsigned holdoff_cnt_width(input int unsigned sync_stages);
        return $clog2(sync_stages + 2);
    endfunction

endpackage

// File: rtl/cdc_handshake_transmitter_sync.sv
// Flop synchronizers for a single asynchronous bit (two- and three-stage).
// AT_POSEDGE_RST selects an active-high (1) or active-low (0) async reset.
module double_flop_synchronizer #(
    parameter int unsigned AT_POSEDGE_RST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic in_i,
    output logic out_o
);

    logic       rst_act;
    logic [1:0] sync_q;

    assign rst_act = (AT_POSEDGE_RST != 0) ? rst : ~rst;

    always_ff @(posedge clk or posedge rst_act) begin
        if (rst_act) begin
            sync_q <= '0;
        end else if (en_i) begin
            sync_q <= {sync_q[0], in_i};
        end
    end

    assign out_o = sync_q[1];

endmodule

module triple_flop_synchronizer #(
    parameter int unsigned AT_POSEDGE_RST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic in_i,
    output logic out_o
);

    logic       rst_act;
    logic [2:0] sync_q;

    assign rst_act = (AT_POSEDGE_RST != 0) ? rst : ~rst;

    always_ff @(posedge clk or posedge rst_act) begin
        if (rst_act) begin
            sync_q <= '0;
        end else if (en_i) begin
            sync_q <= {sync_q[1:0], in_i};
        end
    end

    assign out_o = sync_q[2];

endmodule

// File: rtl/cdc_handshake_transmitter.sv
// Source-domain transmitter of a four-phase req/ack crossing: accepts a word,
// holds it on data_out while req_out is high, and completes on synchronized ack.
module cdc_handshake_transmitter
    import cdc_handshake_transmitter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in,
    output logic                  done
);

    localparam int unsigned CNT_W = holdoff_cnt_width(SYNC_STAGES);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(SYNC_STAGES + 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic                    ack_sync;

    generate
        if (SYNC_STAGES == 2) begin : g_sync2
            double_flop_synchronizer #(
                .AT_POSEDGE_RST(1)
            ) u_ack_sync (
                .clk  (clk),
                .rst  (rst),
                .en_i (1'b1),
                .in_i (ack_in),
                .out_o(ack_sync)
            );
        end else if (SYNC_STAGES == 3) begin : g_sync3
            triple_flop_synchronizer #(
                .AT_POSEDGE_RST(1)
            ) u_ack_sync (
                .clk  (clk),
                .rst  (rst),
                .en_i (1'b1),
                .in_i (ack_in),
                .out_o(ack_sync)
            );
        end else begin : g_bad_stages
            $error("cdc_handshake_transmitter: SYNC_STAGES must be 2 or 3");
            assign ack_sync = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            // Wait for ack to be seen low long enough that a destination still
            // finishing a pre-reset handshake cannot be mistaken for a new ack.
            ST_HOLDOFF: begin
                if (ack_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLDOFF_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    req_d   = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HOLDOFF;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign req_out  = req_q;
    assign data_out = data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_cdc_handshake_transmitter.sv
// Directed bench for cdc_handshake_transmitter: one instance per legal
// SYNC_STAGES value, with the active one selected by sel3.
module tb_cdc_handshake_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, ack_in, sel3;
    logic [7:0] in_data;

    logic       valid2, ack2, rdy2, req2, done2;
    logic       valid3, ack3, rdy3, req3, done3;
    logic [7:0] dout2, dout3;
    logic       rdy, req, done;
    logic [7:0] dout;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          n = 2;

    assign valid2 = in_valid & ~sel3;
    assign ack2   = ack_in & ~sel3;
    assign valid3 = in_valid & sel3;
    assign ack3   = ack_in & sel3;
    assign rdy    = sel3 ? rdy3  : rdy2;
    assign req    = sel3 ? req3  : req2;
    assign done   = sel3 ? done3 : done2;
    assign dout   = sel3 ? dout3 : dout2;

    cdc_handshake_transmitter #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .in_valid(valid2),
        .in_ready(rdy2),
        .in_data (in_data),
        .req_out (req2),
        .data_out(dout2),
        .ack_in  (ack2),
        .done    (done2)
    );

    cdc_handshake_transmitter #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(3)
    ) dut3 (
        .clk     (clk),
        .rst     (rst),
        .in_valid(valid3),
        .in_ready(rdy3),
        .in_data (in_data),
        .req_out (req3),
        .data_out(dout3),
        .ack_in  (ack3),
        .done    (done3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    // Accept w (block must be idle), then play the destination: ack rises
    // 3 cycles after req and drops 2 cycles after req falls.
    task automatic xfer(input logic [7:0] w, input logic [7:0] nxt, input logic keep);
        in_valid = 1'b1;
        in_data  = w;
        step();
        chk1("acc_req", req, 1'b1);
        chk8("acc_data", dout, w);
        chk1("acc_rdy", rdy, 1'b0);
        chk1("acc_done", done, 1'b0);
        in_valid = keep;
        in_data  = nxt;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("req_hold", req, 1'b1);
            chk8("data_hold", dout, w);
        end
        ack_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            chk1("req_wait_ack", req, 1'b1);
        end
        step();
        chk1("req_fall", req, 1'b0);
        chk8("data_rel", dout, w);
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("rel_rdy", rdy, 1'b0);
            chk1("rel_done", done, 1'b0);
            chk1("rel_req", req, 1'b0);
        end
        ack_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk1("done_early", done, 1'b0);
            chk1("rdy_early", rdy, 1'b0);
            chk8("data_rel2", dout, w);
        end
        step();
        chk1("done_pulse", done, 1'b1);
        chk1("rdy_back", rdy, 1'b1);
        chk1("done_req", req, 1'b0);
        chk8("done_data", dout, w);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ack_in   = 1'b0;
        sel3     = 1'b0;

        // Reset state and holdoff release (SYNC_STAGES=2: 4 cycles).
        step();
        step();
        chk1("rst_rdy", rdy, 1'b0);
        chk1("rst_req", req, 1'b0);
        chk8("rst_data", dout, 8'h00);
        chk1("rst_done", done, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk1("holdoff_rdy", rdy, i == 4);
            chk1("holdoff_req", req, 1'b0);
            chk8("holdoff_data", dout, 8'h00);
        end

        // Single transfer of 0xA5; data held afterwards while in_data changes.
        xfer(8'hA5, 8'hFF, 1'b0);
        step();
        chk1("a5_done_once", done, 1'b0);
        chk1("a5_rdy", rdy, 1'b1);
        chk8("a5_data_kept", dout, 8'hA5);

        // Back-to-back with in_valid held high.
        xfer(8'h01, 8'h02, 1'b1);
        xfer(8'h02, 8'h03, 1'b1);
        xfer(8'h03, 8'h00, 1'b0);
        step();
        chk1("b2b_done_once", done, 1'b0);
        chk1("b2b_no_fourth", req, 1'b0);
        chk1("b2b_rdy", rdy, 1'b1);

        // Spurious ack in IDLE, then ack held high across reset.
        ack_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("ack_idle_rdy", rdy, 1'b1);
            chk1("ack_idle_req", req, 1'b0);
        end
        rst = 1'b1;
        #1;
        chk1("rst_ack_rdy", rdy, 1'b0);
        chk8("rst_ack_data", dout, 8'h00);
        step();
        step();
        rst = 1'b0;
        in_data = 8'h77;
        for (int i = 1; i <= 8; i++) begin
            in_valid = (i % 2) == 1;
            step();
            chk1("ackhi_rdy", rdy, 1'b0);
            chk1("ackhi_req", req, 1'b0);
            chk8("ackhi_data", dout, 8'h00);
        end
        in_valid = 1'b0;
        ack_in   = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk1("ackdrop_rdy", rdy, i == 6);
        end

        // Reset while in REQ with 0x3C.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        chk1("r5_req", req, 1'b1);
        chk8("r5_data", dout, 8'h3C);
        in_valid = 1'b0;
        step();
        chk1("r5_req_hold", req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("r5_async_req", req, 1'b0);
        chk8("r5_async_data", dout, 8'h00);
        chk1("r5_async_rdy", rdy, 1'b0);
        step();
        chk1("r5_rst_done", done, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk1("r5_recover_rdy", rdy, i == 4);
            chk1("r5_recover_done", done, 1'b0);
            chk1("r5_recover_req", req, 1'b0);
        end

        // SYNC_STAGES=3: 5-cycle holdoff, IDLE ack glitch, 3-cycle latencies.
        sel3 = 1'b1;
        n    = 3;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk1("s3_holdoff_rdy", rdy, i == 5);
            chk1("s3_holdoff_req", req, 1'b0);
        end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk1("s3_glitch_rdy", rdy, 1'b1);
            chk1("s3_glitch_req", req, 1'b0);
            chk1("s3_glitch_done", done, 1'b0);
        end
        xfer(8'hA5, 8'hFF, 1'b0);
        step();
        chk1("s3_done_once", done, 1'b0);
        chk1("s3_rdy", rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
